pri_en: RTL and testbench

- Registered dual priority encoder over a DE_SIZE-bit request vector.
- Each cycle it reports two indices:
  - the highest set bit of the vector;
  - the lowest set bit in the range [DE_SIZE-1:1].
- It also reports whether any bit is set.
- Used by allocation/retire logic (e.g. ROB or free-list slot selection) to pick head/tail candidates from a bit vector.

---
 rtl/pri_en.sv | 62 ++++++
 tb/tb_pri_en.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/pri_en.sv
// Registered dual priority encoder: highest set bit of decode, lowest set bit
// of decode[DE_SIZE-1:1], and an any-bit-set flag, all with one cycle of latency.
module pri_en #(
  parameter int DE_SIZE = 32,
  parameter int EN_SIZE = 5
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [DE_SIZE-1:0] decode,
  output logic [EN_SIZE-1:0] encode_high,
  output logic [EN_SIZE-1:0] encode_low,
  output logic               valid
);

  logic [EN_SIZE-1:0] high_d;
  logic [EN_SIZE-1:0] high_q;
  logic [EN_SIZE-1:0] low_d;
  logic [EN_SIZE-1:0] low_q;
  logic               valid_d;
  logic               valid_q;

  // Priority encoders: later loop iterations overwrite earlier hits, so the
  // upward scan keeps the highest index and the downward scan keeps the lowest.
  always_comb begin
    high_d  = {EN_SIZE{1'b0}};
    low_d   = {EN_SIZE{1'b0}};
    valid_d = |decode;
    for (int i = 0; i < DE_SIZE; i++) begin
      if (decode[i]) begin
        high_d = EN_SIZE'(i);
      end else begin
        high_d = high_d;
      end
    end
    // Bit 0 is deliberately excluded from the low search.
    for (int j = DE_SIZE - 1; j >= 1; j--) begin
      if (decode[j]) begin
        low_d = EN_SIZE'(j);
      end else begin
        low_d = low_d;
      end
    end
  end

  // Output registers; synchronous reset wins over the normal load.
  always_ff @(posedge clock) begin
    if (reset) begin
      high_q  <= {EN_SIZE{1'b0}};
      low_q   <= {EN_SIZE{1'b0}};
      valid_q <= 1'b0;
    end else begin
      high_q  <= high_d;
      low_q   <= low_d;
      valid_q <= valid_d;
    end
  end

  assign encode_high = high_q;
  assign encode_low  = low_q;
  assign valid       = valid_q;

endmodule

// File: tb/tb_pri_en.sv
// Scoreboard bench for pri_en: the driver queues expected outputs from an
// arithmetic reference model, a monitor pops and compares one per cycle.
module tb_pri_en;

  localparam int DE = 32;
  localparam int EN = 5;

  logic          clock;
  logic          reset;
  logic [DE-1:0] decode;
  logic [EN-1:0] encode_high;
  logic [EN-1:0] encode_low;
  logic          valid;

  typedef struct {
    logic [EN-1:0] high;
    logic [EN-1:0] low;
    logic          vld;
    string         name;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  pri_en #(.DE_SIZE(DE), .EN_SIZE(EN)) dut (
    .clock       (clock),
    .reset       (reset),
    .decode      (decode),
    .encode_high (encode_high),
    .encode_low  (encode_low),
    .valid       (valid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // floor(log2(d)) by repeated halving; 0 for d==0.
  function automatic int ref_high(input logic [DE-1:0] d);
    logic [DE-1:0] x;
    int n;
    x = d;
    n = 0;
    while (x > 1) begin
      x = x >> 1;
      n++;
    end
    return n;
  endfunction

  // Isolate the lowest set bit above bit 0 with two's complement, then log2.
  function automatic int ref_low(input logic [DE-1:0] d);
    logic [DE-1:0] x;
    x = d;
    x[0] = 1'b0;
    if (x == '0) return 0;
    return ref_high(x & (~x + 1));
  endfunction

  task automatic apply(input logic [DE-1:0] d, input logic r, input string nm);
    exp_t e;
    @(negedge clock);
    decode = d;
    reset  = r;
    e.high = r ? 5'd0 : EN'(ref_high(d));
    e.low  = r ? 5'd0 : EN'(ref_low(d));
    e.vld  = r ? 1'b0 : (d != '0);
    e.name = nm;
    sb.push_back(e);
  endtask

  task automatic check(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, req);
    end
  endtask

  // Monitor: outputs are updated every edge, so one expectation per cycle.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check({e.name, ".high"}, int'(encode_high), int'(e.high));
        check({e.name, ".low"},  int'(encode_low),  int'(e.low));
        check({e.name, ".valid"}, int'(valid),      int'(e.vld));
      end
    end
  end

  initial begin
    logic [DE-1:0] d;
    logic          r;
    int            drain;
    reset  = 1'b1;
    decode = 32'hffff_ffff;

    apply(32'hffff_ffff, 1'b1, "reset0");
    apply(32'hffff_ffff, 1'b1, "reset1");
    apply(32'hffff_ffff, 1'b0, "all_ones");
    apply(32'h0f00_0000, 1'b0, "group");
    apply(32'h0f00_00f0, 1'b0, "two_groups");
    apply(32'h0000_0000, 1'b0, "zero");
    apply(32'h0000_0001, 1'b0, "bit0");
    apply(32'h0000_0003, 1'b0, "bits01");
    apply(32'h8000_0000, 1'b0, "msb");
    apply(32'h8000_0001, 1'b0, "msb_bit0");
    apply(32'h8000_0001, 1'b1, "mid_reset");
    apply(32'h0000_0010, 1'b0, "post_reset");

    for (int k = 1; k < DE; k++) begin
      d = '0;
      d[k] = 1'b1;
      apply(d, 1'b0, $sformatf("walk%0d", k));
    end

    for (int n = 0; n < 1000; n++) begin
      case ($urandom_range(0, 3))
        0:       d = $urandom & $urandom & $urandom;
        1:       d = 32'h1 << $urandom_range(0, DE - 1);
        default: d = $urandom;
      endcase
      r = ($urandom_range(0, 99) < 3);
      apply(d, r, $sformatf("rand%0d", n));
    end

    drain = 0;
    while (sb.size() > 0 && drain < 10) begin
      @(posedge clock);
      drain++;
    end
    #2;
    if (sb.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
